// File: rtl/vga_pkg.sv
// Shared display constants and RGB565 colour definitions
// for the VGA pixel-source slice.
package vga_pkg;

  localparam int H_DISP = 640;
  localparam int V_DISP = 480;

  typedef logic [15:0] rgb565_t;

  localparam rgb565_t WHITE = 16'hFFFF;
  localparam rgb565_t BLUE  = 16'h001F;
  localparam rgb565_t BLACK = 16'h0000;

endpackage

// File: rtl/vga_frame_tick.sv
// Detects the last visible pixel of a frame and divides
// frames down to the block move tick.
module vga_frame_tick #(
  parameter int H_DISP    = 640,
  parameter int V_DISP    = 480,
  parameter int SPEED_DIV = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_xpos,
  input  logic [9:0] i_ypos,
  output logic       o_frame_end,
  output logic       o_move_tick
);

  logic       w_last;
  logic       r_last_d;
  logic [7:0] r_fcnt;

  // ypos is row+1, so the last row is ypos == V_DISP
  assign w_last = (i_xpos == 10'(H_DISP - 1)) &&
                  (i_ypos == 10'(V_DISP));

  // Edge-detect so a held coordinate still yields one pulse
  assign o_frame_end = w_last && !r_last_d;
  assign o_move_tick = o_frame_end &&
                       (r_fcnt == 8'(SPEED_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_d <= 1'b0;
      r_fcnt   <= 8'd0;
    end else begin
      r_last_d <= w_last;
      if (o_frame_end) begin
        if (o_move_tick) r_fcnt <= 8'd0;
        else             r_fcnt <= r_fcnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_block_move.sv
// Pixel source: white border, black field and a bouncing
// blue square, one cycle from coordinate to colour.
module vga_block_move #(
  parameter int H_DISP    = 640,
  parameter int V_DISP    = 480,
  parameter int BORDER    = 10,
  parameter int BLOCK_W   = 40,
  parameter int STEP      = 2,
  parameter int SPEED_DIV = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [9:0]  pixel_xpos,
  input  logic [9:0]  pixel_ypos,
  output logic [15:0] pixel_data
);

  import vga_pkg::*;

  localparam logic [10:0] X_MIN = 11'(BORDER);
  localparam logic [10:0] Y_MIN = 11'(BORDER);
  localparam logic [10:0] X_MAX = 11'(H_DISP - BORDER - BLOCK_W);
  localparam logic [10:0] Y_MAX = 11'(V_DISP - BORDER - BLOCK_W);
  localparam logic [10:0] STP   = 11'(STEP);
  localparam logic [10:0] BW    = 11'(BLOCK_W);
  localparam logic [10:0] BRD   = 11'(BORDER);
  localparam logic [10:0] X_BHI = 11'(H_DISP - BORDER);
  localparam logic [10:0] Y_BHI = 11'(V_DISP - BORDER);

  logic        w_frame_end;
  logic        w_move_tick;
  logic [10:0] w_col;
  logic [10:0] w_row;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_blank;
  logic        w_border;
  logic        w_block;
  rgb565_t     w_color;
  logic [9:0]  w_nx;
  logic [9:0]  w_ny;
  logic        w_ndx;
  logic        w_ndy;

  rgb565_t     r_pixel;
  logic [9:0]  r_blk_x;
  logic [9:0]  r_blk_y;
  logic        r_dir_x;
  logic        r_dir_y;

  vga_frame_tick #(
    .H_DISP    (H_DISP),
    .V_DISP    (V_DISP),
    .SPEED_DIV (SPEED_DIV)
  ) u_tick (
    .i_clk       (vga_clk),
    .i_rst       (sys_rst),
    .i_xpos      (pixel_xpos),
    .i_ypos      (pixel_ypos),
    .o_frame_end (w_frame_end),
    .o_move_tick (w_move_tick)
  );

  assign w_col = {1'b0, pixel_xpos};
  assign w_row = {1'b0, pixel_ypos} - 11'd1;
  assign w_bx  = {1'b0, r_blk_x};
  assign w_by  = {1'b0, r_blk_y};

  assign w_blank  = (pixel_xpos == 10'd0) &&
                    (pixel_ypos == 10'd0);
  assign w_border = (w_col < BRD) || (w_col >= X_BHI) ||
                    (w_row < BRD) || (w_row >= Y_BHI);
  assign w_block  = (w_col >= w_bx) && (w_col < w_bx + BW) &&
                    (w_row >= w_by) && (w_row < w_by + BW);

  always_comb begin
    w_color = BLACK;
    if (w_blank)       w_color = BLACK;
    else if (w_border) w_color = WHITE;
    else if (w_block)  w_color = BLUE;
  end

  always_comb begin
    w_nx  = r_blk_x;
    w_ndx = r_dir_x;
    if (r_dir_x) begin
      if (w_bx + STP >= X_MAX) begin
        w_nx  = X_MAX[9:0];
        w_ndx = 1'b0;
      end else begin
        w_nx = r_blk_x + 10'(STEP);
      end
    end else begin
      if (w_bx <= X_MIN + STP) begin
        w_nx  = X_MIN[9:0];
        w_ndx = 1'b1;
      end else begin
        w_nx = r_blk_x - 10'(STEP);
      end
    end
  end

  always_comb begin
    w_ny  = r_blk_y;
    w_ndy = r_dir_y;
    if (r_dir_y) begin
      if (w_by + STP >= Y_MAX) begin
        w_ny  = Y_MAX[9:0];
        w_ndy = 1'b0;
      end else begin
        w_ny = r_blk_y + 10'(STEP);
      end
    end else begin
      if (w_by <= Y_MIN + STP) begin
        w_ny  = Y_MIN[9:0];
        w_ndy = 1'b1;
      end else begin
        w_ny = r_blk_y - 10'(STEP);
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      r_pixel <= BLACK;
      r_blk_x <= X_MIN[9:0];
      r_blk_y <= Y_MIN[9:0];
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else begin
      r_pixel <= w_color;
      if (w_move_tick) begin
        r_blk_x <= w_nx;
        r_blk_y <= w_ny;
        r_dir_x <= w_ndx;
        r_dir_y <= w_ndy;
      end
    end
  end

  assign pixel_data = r_pixel;

endmodule

// File: tb/tb_vga_block_move.sv
// Scoreboard bench: two instances (move every frame, every
// third frame) checked against a frame-level motion model.
module tb_vga_block_move;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  xpos = '0;
  logic [9:0]  ypos = '0;
  logic [15:0] pd1;
  logic [15:0] pd3;

  always #5 clk = ~clk;

  vga_block_move u1 (
    .vga_clk    (clk),
    .sys_rst    (rst),
    .pixel_xpos (xpos),
    .pixel_ypos (ypos),
    .pixel_data (pd1)
  );

  vga_block_move #(.SPEED_DIV(3)) u3 (
    .vga_clk    (clk),
    .sys_rst    (rst),
    .pixel_xpos (xpos),
    .pixel_ypos (ypos),
    .pixel_data (pd3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] q1[$];
  logic [15:0] q3[$];
  logic        drv_v = 1'b0;
  logic        mon_v = 1'b0;

  int bx[2];
  int by[2];
  int dx[2];
  int dy[2];
  int fc[2];
  int dv[2];

  always @(posedge clk) mon_v <= drv_v;

  always @(negedge clk) begin
    logic [15:0] e1;
    logic [15:0] e3;
    if (mon_v) begin
      if (q1.size() == 0 || q3.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL underflow: no expected value queued");
      end else begin
        e1 = q1.pop_front();
        e3 = q3.pop_front();
        n_cmp++;
        if (pd1 !== e1) begin
          n_bad++;
          $display("FAIL pix_div1 t=%0t got %h want %h",
                   $time, pd1, e1);
        end
        n_cmp++;
        if (pd3 !== e3) begin
          n_bad++;
          $display("FAIL pix_div3 t=%0t got %h want %h",
                   $time, pd3, e3);
        end
      end
    end
  end

  function automatic logic [15:0] color(int c, int yp,
                                        int bxx, int byy);
    int r;
    if (c == 0 && yp == 0) return 16'h0000;
    r = yp - 1;
    if (c < 10 || c >= 630 || r < 10 || r >= 470)
      return 16'hFFFF;
    if (c >= bxx && c < bxx + 40 && r >= byy && r < byy + 40)
      return 16'h001F;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      bx[i] = 10; by[i] = 10;
      dx[i] = 1;  dy[i] = 1;
      fc[i] = 0;
    end
  endtask

  task automatic move(int i);
    if (dx[i] == 1) begin
      bx[i] = bx[i] + 2;
      if (bx[i] >= 590) begin bx[i] = 590; dx[i] = 0; end
    end else begin
      bx[i] = bx[i] - 2;
      if (bx[i] <= 10) begin bx[i] = 10; dx[i] = 1; end
    end
    if (dy[i] == 1) begin
      by[i] = by[i] + 2;
      if (by[i] >= 430) begin by[i] = 430; dy[i] = 0; end
    end else begin
      by[i] = by[i] - 2;
      if (by[i] <= 10) begin by[i] = 10; dy[i] = 1; end
    end
  endtask

  task automatic drive(int c, int yp);
    @(posedge clk);
    #1;
    rst = 1'b0;
    xpos = 10'(c);
    ypos = 10'(yp);
    drv_v = 1'b1;
    q1.push_back(color(c, yp, bx[0], by[0]));
    q3.push_back(color(c, yp, bx[1], by[1]));
  endtask

  task automatic drive_exp(int c, int yp,
                           logic [15:0] e1, logic [15:0] e3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    xpos = 10'(c);
    ypos = 10'(yp);
    drv_v = 1'b1;
    q1.push_back(e1);
    q3.push_back(e3);
  endtask

  task automatic do_reset(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      xpos = 10'($urandom_range(0, 639));
      ypos = 10'($urandom_range(1, 480));
      drv_v = 1'b1;
      q1.push_back(16'h0000);
      q3.push_back(16'h0000);
    end
    model_reset();
  endtask

  task automatic frame_done();
    for (int i = 0; i < 2; i++) begin
      fc[i]++;
      if (fc[i] == dv[i]) begin
        fc[i] = 0;
        move(i);
      end
    end
  endtask

  task automatic end_frame();
    drive(639, 480);
    frame_done();
    drive(0, 0);
  endtask

  task automatic end_frame_hold();
    drive(639, 480);
    drive(639, 480);
    frame_done();
    drive(0, 0);
  endtask

  task automatic probe(int i);
    int c;
    int r;
    case ($urandom_range(0, 7))
      0: begin c = bx[i] - 1;  r = by[i];      end
      1: begin c = bx[i];      r = by[i];      end
      2: begin c = bx[i] + 39; r = by[i];      end
      3: begin c = bx[i] + 40; r = by[i];      end
      4: begin c = bx[i];      r = by[i] - 1;  end
      5: begin c = bx[i];      r = by[i] + 39; end
      6: begin c = bx[i] + 39; r = by[i] + 39; end
      default: begin c = bx[i] + 39; r = by[i] + 40; end
    endcase
    drive(c, r + 1);
  endtask

  initial begin
    dv[0] = 1;
    dv[1] = 3;
    model_reset();
    do_reset(3);

    drive_exp(20, 21, 16'h001F, 16'h001F);
    drive_exp(0, 2, 16'hFFFF, 16'hFFFF);
    drive_exp(300, 201, 16'h0000, 16'h0000);

    drive_exp(9, 51, 16'hFFFF, 16'hFFFF);
    drive_exp(10, 51, 16'h0000, 16'h0000);
    drive_exp(60, 51, 16'h0000, 16'h0000);
    drive_exp(0, 0, 16'h0000, 16'h0000);

    drive_exp(55, 56, 16'h0000, 16'h0000);
    repeat (3) end_frame();
    drive_exp(55, 56, 16'h001F, 16'h0000);
    drive_exp(16, 17, 16'h001F, 16'h001F);
    drive_exp(15, 17, 16'h0000, 16'h001F);

    end_frame();
    drive(100, 100);
    drive(300, 300);
    do_reset(2);
    drive_exp(10, 11, 16'h001F, 16'h001F);
    drive_exp(50, 11, 16'h0000, 16'h0000);
    drive_exp(49, 50, 16'h001F, 16'h001F);
    repeat (2) end_frame();
    drive_exp(10, 11, 16'h0000, 16'h001F);
    end_frame();
    drive_exp(10, 11, 16'h0000, 16'h0000);
    drive_exp(12, 13, 16'h0000, 16'h001F);

    for (int f = 0; f < 6200; f++) begin
      if (f == 100) end_frame_hold();
      else          end_frame();
      probe(0);
      probe(1);
      drive($urandom_range(0, 639), $urandom_range(1, 480));
    end

    @(posedge clk);
    #1;
    drv_v = 1'b0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
